reg_file_read: RTL and testbench

REG_FILE_READ -- requirements
Module: reg_file_read

---
 rtl/reg_file_read.sv | 117 +++++++++++
 tb/tb_reg_file_read.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_read.sv
// rtl/reg_file_read.sv - two-port register file read sequencer with write bypass
module reg_file_read #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Read_Start,
    input  logic [4:0]        Instr25_21,
    input  logic [4:0]        Instr20_16,
    input  logic              RegWrite,
    input  logic [4:0]        Write_Reg,
    input  logic [DATA_W-1:0] Write_Data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              Read_Valid,
    output logic              Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_en;

    assign wr_en = RegWrite && (Write_Reg != 5'd0) && (32'(Write_Reg) < NUM_REGS);

    // Address 0 is hardwired to zero; a same-cycle write to the read address is forwarded.
    function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (addr == 5'd0) begin
            val = '0;
        end else if (wr_en && (Write_Reg == addr)) begin
            val = Write_Data;
        end else if (32'(addr) < NUM_REGS) begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[Write_Reg] = Write_Data;
        end
    end

    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Read_Start) begin
                    rs_d    = Instr25_21;
                    rt_d    = Instr20_16;
                    state_d = READ;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                a_d     = read_port(rs_q);
                b_d     = read_port(rt_q);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            regs_q  <= regs_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign Read_Valid = valid_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_reg_file_read.sv
// tb/tb_reg_file_read.sv - directed self-checking bench for reg_file_read
module tb_reg_file_read;

    logic        clk;
    logic        reset;
    logic        Read_Start;
    logic [4:0]  Instr25_21;
    logic [4:0]  Instr20_16;
    logic        RegWrite;
    logic [4:0]  Write_Reg;
    logic [31:0] Write_Data;
    logic [31:0] A;
    logic [31:0] B;
    logic        Read_Valid;
    logic        Busy;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_read #(.DATA_W(32), .NUM_REGS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Read_Start (Read_Start),
        .Instr25_21 (Instr25_21),
        .Instr20_16 (Instr20_16),
        .RegWrite   (RegWrite),
        .Write_Reg  (Write_Reg),
        .Write_Data (Write_Data),
        .A          (A),
        .B          (B),
        .Read_Valid (Read_Valid),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        RegWrite   = 1'b1;
        Write_Reg  = addr;
        Write_Data = data;
        step();
        RegWrite   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
        Read_Start = 1'b1;
        Instr25_21 = rs;
        Instr20_16 = rt;
        step();
        Read_Start = 1'b0;
        step();
    endtask

    initial begin
        reset      = 1'b1;
        Read_Start = 1'b0;
        Instr25_21 = 5'd0;
        Instr20_16 = 5'd0;
        RegWrite   = 1'b0;
        Write_Reg  = 5'd0;
        Write_Data = 32'd0;

        #3;
        check("reset_A", A, 32'd0);
        check("reset_B", B, 32'd0);
        check("reset_valid", {31'd0, Read_Valid}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // first read after reset: registers all zero
        Read_Start = 1'b1;
        Instr25_21 = 5'd5;
        Instr20_16 = 5'd6;
        step();
        check("t1_busy_in_read", {31'd0, Busy}, 32'd1);
        check("t1_valid_in_read", {31'd0, Read_Valid}, 32'd0);
        Read_Start = 1'b0;
        step();
        check("t1_A", A, 32'd0);
        check("t1_B", B, 32'd0);
        check("t1_valid", {31'd0, Read_Valid}, 32'd1);
        check("t1_busy_after", {31'd0, Busy}, 32'd0);
        step();
        check("t1_valid_drop", {31'd0, Read_Valid}, 32'd0);

        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'h12345678);
        rd(5'd5, 5'd31);
        check("t2_A", A, 32'hDEADBEEF);
        check("t2_B", B, 32'h12345678);
        check("t2_valid", {31'd0, Read_Valid}, 32'd1);

        wr(5'd5, 32'h11111111);
        check("t2_hold_A", A, 32'hDEADBEEF);
        check("t2_valid_low", {31'd0, Read_Valid}, 32'd0);

        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        check("t3_A_r0", A, 32'd0);
        check("t3_B_r0", B, 32'd0);

        // write to r0 during the READ cycle must not bypass
        Read_Start = 1'b1;
        Instr25_21 = 5'd0;
        Instr20_16 = 5'd5;
        step();
        Read_Start = 1'b0;
        RegWrite   = 1'b1;
        Write_Reg  = 5'd0;
        Write_Data = 32'hFFFFFFFF;
        step();
        RegWrite   = 1'b0;
        check("t3_A_r0_bypass", A, 32'd0);
        check("t3_B_r5", B, 32'h11111111);

        // bypass during READ, duplicate address, ignored restart
        wr(5'd7, 32'h00000001);
        Read_Start = 1'b1;
        Instr25_21 = 5'd7;
        Instr20_16 = 5'd7;
        step();
        RegWrite   = 1'b1;
        Write_Reg  = 5'd7;
        Write_Data = 32'hA5A5A5A5;
        Instr25_21 = 5'd3;
        Instr20_16 = 5'd3;
        step();
        Read_Start = 1'b0;
        RegWrite   = 1'b0;
        check("t4_A_bypass", A, 32'hA5A5A5A5);
        check("t4_B_bypass", B, 32'hA5A5A5A5);
        check("t4_valid", {31'd0, Read_Valid}, 32'd1);
        check("t4_busy_no_restart", {31'd0, Busy}, 32'd0);
        step();
        check("t4_single_pulse", {31'd0, Read_Valid}, 32'd0);
        check("t4_busy_idle", {31'd0, Busy}, 32'd0);

        // write at the acceptance edge is seen by the load
        Read_Start = 1'b1;
        Instr25_21 = 5'd12;
        Instr20_16 = 5'd0;
        RegWrite   = 1'b1;
        Write_Reg  = 5'd12;
        Write_Data = 32'hCAFE0001;
        step();
        Read_Start = 1'b0;
        RegWrite   = 1'b0;
        step();
        check("t4b_accept_edge_write", A, 32'hCAFE0001);

        // reset in the middle of a READ
        wr(5'd3, 32'h33333333);
        Read_Start = 1'b1;
        Instr25_21 = 5'd3;
        Instr20_16 = 5'd3;
        step();
        Read_Start = 1'b0;
        check("t5_busy_pre", {31'd0, Busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_busy_async", {31'd0, Busy}, 32'd0);
        check("t5_A_async", A, 32'd0);
        check("t5_B_async", B, 32'd0);
        check("t5_valid_async", {31'd0, Read_Valid}, 32'd0);
        RegWrite   = 1'b1;
        Write_Reg  = 5'd4;
        Write_Data = 32'h44444444;
        @(posedge clk);
        #1;
        check("t5_no_pulse", {31'd0, Read_Valid}, 32'd0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b0;
        rd(5'd3, 5'd4);
        check("t5_r3_cleared", A, 32'd0);
        check("t5_r4_ignored", B, 32'd0);
        check("t5_valid_after", {31'd0, Read_Valid}, 32'd1);

        // back-to-back with Read_Start held high
        wr(5'd31, 32'h00000031);
        Read_Start = 1'b1;
        Instr25_21 = 5'd31;
        Instr20_16 = 5'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t6_busy_%0d", i), {31'd0, Busy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t6_valid_%0d", i), {31'd0, Read_Valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        Read_Start = 1'b0;
        check("t6_A", A, 32'h00000031);
        check("t6_B", B, 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
